// File: rtl/sap_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sap_datapath
//  Description : SAP-1 W-bus datapath with PC, MAR, 16x8 RAM, IR, A, B, an
//                add/sub ALU and an output register, plus a RAM program-load port.
//  Revision    : 1.0  initial release
// ============================================================================
module sap_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = DATA_W - ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       controller,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [OPC_W-1:0]  operation_code,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] w_bus,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              halted,
    output logic              bus_conflict
);

    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]   c_sum_one = {{DATA_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_carry;
    logic              r_zero;
    logic [DATA_W-1:0] r_ram [2**ADDR_W];

    logic w_cp, w_ep, w_lm_n, w_ce_n, w_li_n, w_ei_n;
    logic w_la_n, w_ea, w_su, w_eu, w_lb_n, w_lo_n;
    logic [4:0]        w_drivers;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_bus_val;

    assign {w_cp, w_ep, w_lm_n, w_ce_n, w_li_n, w_ei_n,
            w_la_n, w_ea, w_su, w_eu, w_lb_n, w_lo_n} = controller;

    // Subtraction is two's complement: A + ~B + 1, so the top bit means "no borrow".
    assign w_sum = w_su ? ({1'b0, r_a} + {1'b0, ~r_b} + c_sum_one)
                        : ({1'b0, r_a} + {1'b0, r_b});
    assign w_alu = w_sum[DATA_W-1:0];

    always_comb begin
        w_bus_val = '0;
        if (w_ep)
            w_bus_val = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
        else if (!w_ce_n)
            w_bus_val = r_ram[r_mar];
        else if (!w_ei_n)
            w_bus_val = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
        else if (w_ea)
            w_bus_val = r_a;
        else if (w_eu)
            w_bus_val = w_alu;
    end

    // Clearing the lowest set bit leaves something only when two or more drivers are on.
    assign w_drivers    = {w_ep, !w_ce_n, !w_ei_n, w_ea, w_eu};
    assign bus_conflict = (w_drivers & (w_drivers - 5'd1)) != 5'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= '0;
            r_mar   <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (!prog_en) begin
            if (w_cp)    r_pc  <= r_pc + c_pc_one;
            if (!w_lm_n) r_mar <= w_bus_val[ADDR_W-1:0];
            if (!w_li_n) r_ir  <= w_bus_val;
            if (!w_lb_n) r_b   <= w_bus_val;
            if (!w_lo_n) r_out <= w_bus_val;
            if (!w_la_n) begin
                r_a <= w_bus_val;
                if (w_eu) begin
                    r_carry <= w_sum[DATA_W];
                    r_zero  <= (w_alu == '0);
                end
            end
        end
    end

    // RAM is untouched by reset so a loaded program survives a restart.
    always_ff @(posedge clock) begin
        if (prog_en)
            r_ram[prog_addr] <= prog_data;
    end

    assign operation_code = r_ir[DATA_W-1 -: OPC_W];
    assign halted         = &operation_code;
    assign out_port       = r_out;
    assign w_bus          = w_bus_val;
    assign carry_flag     = r_carry;
    assign zero_flag      = r_zero;

endmodule
`default_nettype wire
